alu_seq: RTL and testbench

- Parametrised, handshaked successor to the combinational SoC ALU.
- Keeps the existing 4-bit opcode map and zero/negative flags.
- Adds a WIDTH parameter, carry and overflow flags, and arithmetic shift right.
- Adds iterative multi-cycle multiply and unsigned divide/remainder, with a valid/ready handshake on input and output so the CPU execute stage can stall on long operations.

---
 rtl/alu_seq.sv | 207 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential SoC ALU: single-cycle logic/arith/shift ops plus iterative
// shift-add multiply and restoring unsigned divide behind valid/ready handshakes.
module alu_seq #(
  parameter int WIDTH  = 32,
  parameter int DIV_EN = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             is_zero,
  output logic             is_negative,
  output logic             is_carry,
  output logic             is_overflow
);

  localparam int CW     = $clog2(WIDTH + 1);
  localparam int SW     = $clog2(WIDTH);
  localparam bit DIV_ON = (DIV_EN != 0);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_DIVU  = 4'd2,  OP_REMU  = 4'd3,
    OP_AND  = 4'd4,  OP_OR   = 4'd5,  OP_XOR   = 4'd6,  OP_NOT   = 4'd7,
    OP_CMP  = 4'd8,  OP_TEST = 4'd9,  OP_CLZ   = 4'd10, OP_SRA   = 4'd11,
    OP_SHL  = 4'd12, OP_SHR  = 4'd13, OP_MULLO = 4'd14, OP_MULHI = 4'd15
  } op_t;

  state_t             r_state;
  logic               r_in_ready, r_out_valid;
  logic [WIDTH-1:0]   r_c;
  logic               r_z, r_n, r_cy, r_ov;
  logic [CW-1:0]      r_cnt;
  logic               r_sel;
  logic [WIDTH-1:0]   r_opa, r_opb;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_quo, r_rem;

  logic [WIDTH:0]     w_add, w_sub;
  logic [WIDTH-1:0]   w_res;
  logic               w_carry, w_ovf, w_big;
  logic [SW-1:0]      w_sh;
  logic [CW-1:0]      w_clz;
  logic               w_is_mul, w_is_div, w_load;
  logic [WIDTH:0]     w_msum;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [WIDTH:0]     w_dsh, w_dsub;
  logic [WIDTH-1:0]   w_rem_nxt, w_quo_nxt;
  logic [WIDTH-1:0]   w_fin;
  logic               w_fin_cy, w_fin_ov;

  assign w_add = {1'b0, a} + {1'b0, b};
  assign w_sub = {1'b0, a} - {1'b0, b};
  assign w_big = (b >= WIDTH'(WIDTH));
  assign w_sh  = b[SW-1:0];

  // ascending scan: the highest set bit is the last one to overwrite the count
  always_comb begin
    w_clz = CW'(WIDTH);
    for (int unsigned i = 0; i < WIDTH; i++)
      if (a[i]) w_clz = CW'(WIDTH - 1 - i);
  end

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        w_res   = w_add[WIDTH-1:0];
        w_carry = w_add[WIDTH];
        w_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res   = w_sub[WIDTH-1:0];
        w_carry = w_sub[WIDTH];
        w_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_XOR:  w_res = a ^ b;
      OP_NOT:  w_res = ~a;
      OP_CMP: begin
        w_carry = w_sub[WIDTH];
        if ($signed(a) < $signed(b)) w_res = '1;
        else if (a != b)             w_res = WIDTH'(1);
      end
      OP_TEST: w_res = a;
      OP_CLZ:  w_res = WIDTH'(w_clz);
      OP_SRA:  w_res = w_big ? {WIDTH{a[WIDTH-1]}} : $unsigned($signed(a) >>> w_sh);
      OP_SHL:  w_res = w_big ? '0 : (a << w_sh);
      OP_SHR:  w_res = w_big ? '0 : (a >> w_sh);
      default: w_res = '0;
    endcase
  end

  assign w_is_mul = (op == OP_MULLO) || (op == OP_MULHI);
  assign w_is_div = DIV_ON && ((op == OP_DIVU) || (op == OP_REMU));

  // multiplier sits in the low half of the accumulator and shifts out as the product shifts in
  assign w_msum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opa} : '0);
  assign w_acc_nxt = {w_msum, r_acc[WIDTH-1:1]};

  // a zero divisor never underflows, so quotient saturates to all-ones and remainder ends as a
  assign w_dsh     = {r_rem, r_quo[WIDTH-1]};
  assign w_dsub    = w_dsh - {1'b0, r_opb};
  assign w_rem_nxt = w_dsub[WIDTH] ? w_dsh[WIDTH-1:0] : w_dsub[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], ~w_dsub[WIDTH]};

  always_comb begin
    case (r_state)
      S_MUL:   w_fin = r_sel ? w_acc_nxt[2*WIDTH-1:WIDTH] : w_acc_nxt[WIDTH-1:0];
      S_DIV:   w_fin = r_sel ? w_rem_nxt : w_quo_nxt;
      default: w_fin = w_res;
    endcase
  end

  assign w_fin_cy = (r_state == S_IDLE) ? w_carry : 1'b0;
  assign w_fin_ov = (r_state == S_IDLE) ? w_ovf   : 1'b0;
  assign w_load   = ((r_state == S_IDLE) && in_valid && !w_is_mul && !w_is_div) ||
                    (((r_state == S_MUL) || (r_state == S_DIV)) && (r_cnt == CW'(1)));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_c         <= '0;
      r_z         <= 1'b0;
      r_n         <= 1'b0;
      r_cy        <= 1'b0;
      r_ov        <= 1'b0;
      r_cnt       <= '0;
      r_sel       <= 1'b0;
      r_opa       <= '0;
      r_opb       <= '0;
      r_acc       <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_opa      <= a;
            r_opb      <= b;
            r_sel      <= op[0];
            r_cnt      <= CW'(WIDTH);
            r_in_ready <= 1'b0;
            if (w_is_mul) begin
              r_acc   <= {{WIDTH{1'b0}}, b};
              r_state <= S_MUL;
            end else if (w_is_div) begin
              r_quo   <= a;
              r_rem   <= '0;
              r_state <= S_DIV;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_MUL: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= S_DONE;
        end
        S_DIV: begin
          r_quo <= w_quo_nxt;
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_load) begin
        r_c         <= w_fin;
        r_z         <= (w_fin == '0);
        r_n         <= w_fin[WIDTH-1];
        r_cy        <= w_fin_cy;
        r_ov        <= w_fin_ov;
        r_out_valid <= 1'b1;
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign c           = r_c;
  assign is_zero     = r_z;
  assign is_negative = r_n;
  assign is_carry    = r_cy;
  assign is_overflow = r_ov;

endmodule

// File: tb/tb_alu_seq.sv
// Directed and model-based checks of alu_seq at WIDTH=32, plus a WIDTH=16 instance.
module tb_alu_seq;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  op;
  logic [31:0] a, b, c;
  logic        z, n, cy, ov;

  logic        v16, rdy16, ovld16, ordy16;
  logic [3:0]  op16;
  logic [15:0] a16, b16, c16;
  logic        z16, n16, cy16, ov16;

  alu_seq #(.WIDTH(32), .DIV_EN(1)) u_dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .is_zero(z), .is_negative(n), .is_carry(cy), .is_overflow(ov)
  );

  alu_seq #(.WIDTH(16), .DIV_EN(1)) u_dut16 (
    .clk(clk), .resetn(resetn), .in_valid(v16), .in_ready(rdy16),
    .op(op16), .a(a16), .b(b16), .out_valid(ovld16), .out_ready(ordy16),
    .c(c16), .is_zero(z16), .is_negative(n16), .is_carry(cy16), .is_overflow(ov16)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [31:0] obs_c;
  logic        obs_z, obs_n, obs_cy, obs_ov;
  int          obs_lat;

  task automatic run(input bit w16, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    if (w16) begin v16 = 1'b1; op16 = o; a16 = x[15:0]; b16 = y[15:0]; end
    else     begin in_valid = 1'b1; op = o; a = x; b = y; end
    check("in_ready_before_accept", w16 ? rdy16 : in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; v16 = 1'b0;
    op = 4'($urandom); a = $urandom; b = $urandom;
    op16 = 4'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
    obs_lat = 0;
    while (!(w16 ? ovld16 : out_valid) && obs_lat < 100) begin
      @(posedge clk); #1;
      obs_lat++;
    end
    obs_c  = w16 ? {16'h0, c16} : c;
    obs_z  = w16 ? z16  : z;
    obs_n  = w16 ? n16  : n;
    obs_cy = w16 ? cy16 : cy;
    obs_ov = w16 ? ov16 : ov;
  endtask

  task automatic drain;
    @(negedge clk);
    out_ready = 1'b1; ordy16 = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; ordy16 = 1'b0;
  endtask

  typedef struct packed {
    logic [31:0] c;
    logic        cy;
    logic        ov;
  } res_t;

  function automatic res_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    res_t r;
    longint sx, sy, s;
    logic [63:0] p;
    bit found;
    r  = '0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      4'd0: begin r.c = x + y; s = sx + sy; r.cy = ({32'h0, x} + {32'h0, y}) > 64'hFFFF_FFFF;
                  r.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd1: begin r.c = x - y; s = sx - sy; r.cy = (x < y);
                  r.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd2: r.c = (y == 0) ? 32'hFFFF_FFFF : x / y;
      4'd3: r.c = (y == 0) ? x : x % y;
      4'd4: r.c = x & y;
      4'd5: r.c = x | y;
      4'd6: r.c = x ^ y;
      4'd7: r.c = ~x;
      4'd8: begin r.c = (sx < sy) ? 32'hFFFF_FFFF : ((sx == sy) ? 32'd0 : 32'd1); r.cy = (x < y); end
      4'd9: r.c = x;
      4'd10: begin
        r.c = 32; found = 1'b0;
        for (int i = 31; i >= 0; i--)
          if (!found && x[i]) begin r.c = 32'(31 - i); found = 1'b1; end
      end
      4'd11: r.c = (y >= 32) ? {32{x[31]}} : 32'($signed(x) >>> y[4:0]);
      4'd12: r.c = (y >= 32) ? 32'd0 : (x << y[4:0]);
      4'd13: r.c = (y >= 32) ? 32'd0 : (x >> y[4:0]);
      4'd14: begin p = {32'h0, x} * {32'h0, y}; r.c = p[31:0];  end
      default: begin p = {32'h0, x} * {32'h0, y}; r.c = p[63:32]; end
    endcase
    return r;
  endfunction

  typedef struct {
    logic [3:0]  o;
    logic [31:0] x, y, ec;
    logic        ez, en, ecy, eov;
    int          elat;
  } vec_t;

  vec_t vecs[$] = '{
    '{4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0, 1, 0, 0},
    '{4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 1, 0, 1, 0},
    '{4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 1, 0, 0, 32},
    '{4'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 0, 0, 32},
    '{4'd2,  32'd100,       32'd7,         32'd14,        0, 0, 0, 0, 32},
    '{4'd3,  32'd100,       32'd7,         32'd2,         0, 0, 0, 0, 32},
    '{4'd2,  32'd5,         32'd0,         32'hFFFF_FFFF, 0, 1, 0, 0, 32},
    '{4'd3,  32'd5,         32'd0,         32'd5,         0, 0, 0, 0, 32},
    '{4'd11, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 0, 1, 0, 0, 0},
    '{4'd11, 32'h8000_0000, 32'd40,        32'hFFFF_FFFF, 0, 1, 0, 0, 0},
    '{4'd12, 32'h0000_0001, 32'd32,        32'h0000_0000, 1, 0, 0, 0, 0},
    '{4'd10, 32'h0000_0000, 32'd0,         32'd32,        0, 0, 0, 0, 0},
    '{4'd10, 32'h0001_0000, 32'd0,         32'd15,        0, 0, 0, 0, 0},
    '{4'd1,  32'd3,         32'd5,         32'hFFFF_FFFE, 0, 1, 1, 0, 0},
    '{4'd1,  32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 0, 0, 0, 1, 0},
    '{4'd8,  32'd5,         32'd3,         32'd1,         0, 0, 0, 0, 0},
    '{4'd8,  32'h8000_0000, 32'd1,         32'hFFFF_FFFF, 0, 1, 0, 0, 0},
    '{4'd13, 32'hF000_0000, 32'd4,         32'h0F00_0000, 0, 0, 0, 0, 0},
    '{4'd12, 32'd3,         32'd0,         32'd3,         0, 0, 0, 0, 0},
    '{4'd7,  32'h0000_0000, 32'd0,         32'hFFFF_FFFF, 0, 1, 0, 0, 0},
    '{4'd6,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 0, 0, 0, 0, 0},
    '{4'd4,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 0, 0, 0, 0, 0},
    '{4'd5,  32'h0F00_0000, 32'h0000_00F0, 32'h0F00_00F0, 0, 0, 0, 0, 0},
    '{4'd9,  32'h8000_0000, 32'd9,         32'h8000_0000, 0, 1, 0, 0, 0},
    '{4'd14, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1, 0, 0, 0, 32},
    '{4'd11, 32'h7000_0000, 32'd31,        32'h0000_0000, 1, 0, 0, 0, 0}
  };

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t        m;
    logic [31:0] x, y;
    in_valid = 0; out_ready = 0; op = 0; a = 0; b = 0;
    v16 = 0; ordy16 = 0; op16 = 0; a16 = 0; b16 = 0;
    resetn = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_c", c, 0);
    check("rst_flags", {z, n, cy, ov}, 0);
    @(negedge clk); resetn = 1;

    foreach (vecs[i]) begin
      run(0, vecs[i].o, vecs[i].x, vecs[i].y);
      check($sformatf("v%0d_op%0d_c", i, vecs[i].o), obs_c, vecs[i].ec);
      check($sformatf("v%0d_z", i), obs_z, vecs[i].ez);
      check($sformatf("v%0d_n", i), obs_n, vecs[i].en);
      check($sformatf("v%0d_cy", i), obs_cy, vecs[i].ecy);
      check($sformatf("v%0d_ov", i), obs_ov, vecs[i].eov);
      check($sformatf("v%0d_lat", i), obs_lat, vecs[i].elat);
      drain();
    end

    // backpressure: result held while out_ready stays low
    run(0, 4'd8, 32'd3, 32'd5);
    check("bp_lat", obs_lat, 0);
    check("bp_cy", cy, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp%0d_out_valid", k), out_valid, 1);
      check($sformatf("bp%0d_in_ready", k), in_ready, 0);
      check($sformatf("bp%0d_c", k), c, 32'hFFFF_FFFF);
      check($sformatf("bp%0d_n", k), n, 1);
    end
    drain();
    check("bp_release_out_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);

    // out_ready while idle has no effect
    @(negedge clk); out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("idle_rdy%0d_out_valid", k), out_valid, 0);
    end
    out_ready = 0;

    // reset in the middle of a divide
    @(negedge clk);
    in_valid = 1; op = 4'd2; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (9) @(posedge clk);
    #1;
    check("div_mid_out_valid", out_valid, 0);
    check("div_mid_in_ready", in_ready, 0);
    #1 resetn = 0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_c", c, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_flags", {z, n, cy, ov}, 0);
    @(negedge clk); resetn = 1;
    run(0, 4'd0, 32'd2, 32'd2);
    check("post_abort_c", obs_c, 4);
    check("post_abort_lat", obs_lat, 0);
    drain();

    // WIDTH=16 instance
    run(1, 4'd15, 32'hFFFF, 32'hFFFF);
    check("w16_mulhi_c", obs_c, 32'hFFFE);
    check("w16_mulhi_lat", obs_lat, 16);
    check("w16_mulhi_n", obs_n, 1);
    drain();
    run(1, 4'd10, 32'h0, 32'h0);
    check("w16_clz0_c", obs_c, 16);
    drain();
    run(1, 4'd12, 32'h1, 32'd16);
    check("w16_shl16_c", obs_c, 0);
    check("w16_shl16_z", obs_z, 1);
    drain();
    run(1, 4'd0, 32'hFFFF, 32'h1);
    check("w16_add_c", obs_c, 0);
    check("w16_add_cy", obs_cy, 1);
    drain();

    // model-based sweep over every opcode
    for (int o = 0; o < 16; o++) begin
      for (int k = 0; k < 20; k++) begin
        x = $urandom;
        y = $urandom;
        if (o == 11 || o == 12 || o == 13) y = $urandom_range(0, 40);
        if ((o == 2 || o == 3) && k == 0) y = 0;
        if ((o == 2 || o == 3) && k > 10) y = y >> $urandom_range(0, 31);
        if (o == 8 && k == 1) y = x;
        if (o == 10) x = x >> $urandom_range(0, 32);
        m = model(4'(o), x, y);
        run(0, 4'(o), x, y);
        check($sformatf("rnd_op%0d_%0d_c", o, k), obs_c, m.c);
        check($sformatf("rnd_op%0d_%0d_flags", o, k), {obs_z, obs_n, obs_cy, obs_ov},
              {m.c == 0, m.c[31], m.cy, m.ov});
        check($sformatf("rnd_op%0d_%0d_lat", o, k), obs_lat,
              (o == 2 || o == 3 || o == 14 || o == 15) ? 32 : 0);
        drain();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
